// File: rtl/wb_mem_slave_if.sv
// wb_mem_slave_if: Wishbone classic bus signals between a master and wb_mem_slave.
interface wb_mem_slave_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  modport master (output cyc, stb, we, adr, wdata, input rdata, ack);
  modport slave (input cyc, stb, we, adr, wdata, output rdata, ack);
endinterface

// File: rtl/wb_mem_slave.sv
// wb_mem_slave: Wishbone classic slave word RAM with programmable wait states.
// Define WB_MEM_RANDOM_WAIT_EN to add 0..3 LFSR-driven extra wait cycles per transfer.
module wb_mem_slave #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          WAIT_STATES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  wb_mem_slave_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;
  state_t      state, state_nxt;
  logic [4:0]  cnt, cnt_nxt, wcount;
  logic [31:0] dat_r;
  logic [31:0] mem [DEPTH_WORDS];
  logic [29:0] woff;
  logic        req, hit, take;
  assign req     = bus.cyc & bus.stb;
  assign woff    = bus.adr[31:2] - ADDR_BASE[31:2];
  assign hit     = (bus.adr >= ADDR_BASE) && (woff < 30'(DEPTH_WORDS));
  assign take    = en && (state_nxt == S_ACK);
  assign bus.ack = (state == S_ACK);
  assign bus.rdata = dat_r;
`ifdef WB_MEM_RANDOM_WAIT_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr <= 16'hACE1;
    else if (en) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign wcount = 5'(WAIT_STATES) + {3'b000, lfsr[1:0]};
`else
  assign wcount = 5'(WAIT_STATES);
`endif
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      S_IDLE: begin
        state_nxt = !req ? S_IDLE : (wcount == 5'd0) ? S_ACK : S_WAIT;
        cnt_nxt   = (req && wcount != 5'd0) ? wcount - 5'd1 : cnt;
      end
      S_WAIT: begin
        state_nxt = !req ? S_IDLE : (cnt == 5'd0) ? S_ACK : S_WAIT;
        cnt_nxt   = (req && cnt != 5'd0) ? cnt - 5'd1 : cnt;
      end
      default: state_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      dat_r <= '0;
    end else if (en) begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (take && !bus.we) dat_r <= hit ? mem[woff[AW-1:0]] : 32'h0;
    end
  // RAM contents survive reset, so it sits outside the reset domain
  always_ff @(posedge clk)
    if (take && bus.we && hit) mem[woff[AW-1:0]] <= bus.wdata;
endmodule

// File: tb/tb_wb_mem_slave.sv
// tb_wb_mem_slave: directed checks of wb_mem_slave with 0, 1 and 3 wait states.
module tb_wb_mem_slave;
  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = '0, wdata = '0;
  logic        ack_m;
  logic [31:0] rdata_m;
  int          sel = 1;
  int          n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  wb_mem_slave_if b0 ();
  wb_mem_slave_if b1 ();
  wb_mem_slave_if b3 ();
  assign b0.cyc = cyc && sel == 0;
  assign b1.cyc = cyc && sel == 1;
  assign b3.cyc = cyc && sel == 3;
  assign {b0.stb, b0.we, b0.adr, b0.wdata} = {stb, we, adr, wdata};
  assign {b1.stb, b1.we, b1.adr, b1.wdata} = {stb, we, adr, wdata};
  assign {b3.stb, b3.we, b3.adr, b3.wdata} = {stb, we, adr, wdata};
  assign ack_m   = sel == 0 ? b0.ack : sel == 1 ? b1.ack : b3.ack;
  assign rdata_m = sel == 0 ? b0.rdata : sel == 1 ? b1.rdata : b3.rdata;
  wb_mem_slave #(.ADDR_BASE(32'h0), .DEPTH_WORDS(16), .WAIT_STATES(0))
    u0 (.clk(clk), .rst_n(rst_n), .en(en), .bus(b0));
  wb_mem_slave #(.ADDR_BASE(32'h0), .DEPTH_WORDS(16), .WAIT_STATES(1))
    u1 (.clk(clk), .rst_n(rst_n), .en(en), .bus(b1));
  wb_mem_slave #(.ADDR_BASE(32'h100), .DEPTH_WORDS(16), .WAIT_STATES(3))
    u3 (.clk(clk), .rst_n(rst_n), .en(en), .bus(b3));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // One full transfer: checks ACK latency in edges, DAT_O during ACK, and the ACK falling
  task automatic xfer(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input int exp_edges, input logic [31:0] exp_rd);
    int edges = 0;
    {cyc, stb, we, adr, wdata} = {1'b1, 1'b1, w, a, d};
    while (edges < 40) begin
      step();
      edges++;
      if (ack_m) break;
    end
    chk({tag, "_lat"}, 32'(edges), 32'(exp_edges));
    chk({tag, "_dat"}, rdata_m, exp_rd);
    {cyc, stb} = 2'b00;
    step();
    chk({tag, "_ackfall"}, 32'(ack_m), 32'd0);
  endtask
  initial begin
    int edges;
    repeat (2) step();
    chk("rst_ack", 32'(ack_m), 32'd0);
    chk("rst_dat", rdata_m, 32'h0);
    #2 rst_n = 1'b1;
    step();
    xfer("wr4",      1'b1, 32'h10, 32'h1234_5678, 2, 32'h0);
    xfer("rd4",      1'b0, 32'h10, 32'h0,         2, 32'h1234_5678);
    xfer("wr8",      1'b1, 32'h20, 32'hDEAD_BEEF, 2, 32'h1234_5678);
    xfer("rd8",      1'b0, 32'h20, 32'h0,         2, 32'hDEAD_BEEF);
    xfer("wr0",      1'b1, 32'h00, 32'hA5A5_0000, 2, 32'hDEAD_BEEF);
    xfer("wr_miss",  1'b1, 32'h40, 32'hFFFF_FFFF, 2, 32'hDEAD_BEEF);
    xfer("rd_miss",  1'b0, 32'h40, 32'h0,         2, 32'h0);
    xfer("rd0_kept", 1'b0, 32'h00, 32'h0,         2, 32'hA5A5_0000);
    xfer("wr15",     1'b1, 32'h3C, 32'h0BAD_F00D, 2, 32'hA5A5_0000);
    xfer("rd15",     1'b0, 32'h3C, 32'h0,         2, 32'h0BAD_F00D);
    // zero wait states with the strobe held: ACK every other cycle
    sel = 0;
    {cyc, stb, we, adr, wdata} = {1'b1, 1'b1, 1'b1, 32'h0, 32'h5};
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("b2b_%0d", i), 32'(ack_m), 32'((i % 2) == 0));
    end
    {cyc, stb} = 2'b00;
    step();
    chk("b2b_idle", 32'(ack_m), 32'd0);
    sel = 3;
    xfer("w3_wr", 1'b1, 32'h108, 32'h1111_1111, 4, 32'h0);
    {cyc, stb, we, adr, wdata} = {1'b1, 1'b1, 1'b1, 32'h108, 32'h2222_2222};
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 1) {cyc, stb} = 2'b00;
      chk($sformatf("abort_%0d", i), 32'(ack_m), 32'd0);
    end
    xfer("w3_rd_kept",  1'b0, 32'h108, 32'h0, 4, 32'h1111_1111);
    xfer("w3_rd_below", 1'b0, 32'h0FC, 32'h0, 4, 32'h0);
    // clock enable dropped for 5 edges while waiting
    {cyc, stb, we, adr} = {1'b1, 1'b1, 1'b0, 32'h108};
    edges = 0;
    while (edges < 40) begin
      step();
      edges++;
      if (ack_m) break;
      if (edges == 1) en = 1'b0;
      if (edges == 6) en = 1'b1;
    end
    chk("en_lat", 32'(edges), 32'd9);
    chk("en_dat", rdata_m, 32'h1111_1111);
    en = 1'b0;
    repeat (2) step();
    chk("en_ack_held", 32'(ack_m), 32'd1);
    {cyc, stb} = 2'b00;
    en = 1'b1;
    step();
    chk("en_ack_fall", 32'(ack_m), 32'd0);
    // async reset mid-WAIT on a read
    sel = 1;
    {cyc, stb, we, adr} = {1'b1, 1'b1, 1'b0, 32'h20};
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("rstw_ack", 32'(ack_m), 32'd0);
    chk("rstw_dat", rdata_m, 32'h0);
    {cyc, stb} = 2'b00;
    #2 rst_n = 1'b1;
    step();
    chk("rstw_idle", 32'(ack_m), 32'd0);
    // async reset mid-ACK
    {cyc, stb, we, adr} = {1'b1, 1'b1, 1'b0, 32'h20};
    repeat (2) step();
    chk("rsta_ack_on", 32'(ack_m), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rsta_ack", 32'(ack_m), 32'd0);
    chk("rsta_dat", rdata_m, 32'h0);
    {cyc, stb} = 2'b00;
    #2 rst_n = 1'b1;
    step();
    // pending write lost when reset hits during WAIT
    sel = 3;
    {cyc, stb, we, adr, wdata} = {1'b1, 1'b1, 1'b1, 32'h108, 32'h3333_3333};
    repeat (2) step();
    #2 rst_n = 1'b0;
    {cyc, stb} = 2'b00;
    #2 rst_n = 1'b1;
    step();
    xfer("rst_wr_lost", 1'b0, 32'h108, 32'h0, 4, 32'h1111_1111);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
